// File: rtl/ic74x194.sv
// Cycle-based 74LS194 4-bit bidirectional universal shift register, sampled by the system clock.
// Define IC74X194_GLITCH_FILTER_EN to add a third sync stage that rejects 1-cycle CLK glitches.
module ic74x194 (
   input  logic clk,
   input  logic rst,
   input  logic port1,
   input  logic port2,
   input  logic port3,
   input  logic port4,
   input  logic port5,
   input  logic port6,
   input  logic port7,
   input  logic port8,
   input  logic port9,
   input  logic port10,
   input  logic port11,
   output logic port12,
   output logic port13,
   output logic port14,
   output logic port15,
   input  logic port16
);

   // Bit positions of the non-clock pins inside the synchronizer vector
   localparam int unsigned IdxClrN = 8;
   localparam int unsigned IdxSr   = 7;
   localparam int unsigned IdxA    = 6;
   localparam int unsigned IdxB    = 5;
   localparam int unsigned IdxC    = 4;
   localparam int unsigned IdxD    = 3;
   localparam int unsigned IdxSl   = 2;
   localparam int unsigned IdxS1   = 1;
   localparam int unsigned IdxS0   = 0;

   logic [8:0] din;
   logic [8:0] d_s1;
   logic [8:0] d_s2;
   logic [8:0] d_use;
   logic       c_s1;
   logic       c_s2;
   logic       c_h;
   logic       pin_edge;
   logic [3:0] q_q;
   logic [3:0] q_d;

   // Supply pins have no function in the emulation
   logic unused_pins;
   assign unused_pins = port8 ^ port16;

   assign din = {port1, port2, port3, port4, port5, port6, port7, port10, port9};

`ifdef IC74X194_GLITCH_FILTER_EN
   logic [8:0] d_s3;
   logic       c_s3;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d_s1 <= '0;
         d_s2 <= '0;
         d_s3 <= '0;
         c_s1 <= 1'b1;
         c_s2 <= 1'b1;
         c_s3 <= 1'b1;
         c_h  <= 1'b1;
      end else begin
         d_s1 <= din;
         d_s2 <= d_s1;
         d_s3 <= d_s2;
         c_s1 <= port11;
         c_s2 <= c_s1;
         c_s3 <= c_s2;
         c_h  <= c_s3;
      end
   end

   // Two consecutive high samples after a low one
   assign pin_edge = c_s3 & c_s2 & ~c_h;
   assign d_use    = d_s3;
`else
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d_s1 <= '0;
         d_s2 <= '0;
         c_s1 <= 1'b1;
         c_s2 <= 1'b1;
         c_h  <= 1'b1;
      end else begin
         d_s1 <= din;
         d_s2 <= d_s1;
         c_s1 <= port11;
         c_s2 <= c_s1;
         c_h  <= c_s2;
      end
   end

   assign pin_edge = c_s2 & ~c_h;
   assign d_use    = d_s2;
`endif

   // q = {QA, QB, QC, QD}; clear dominates and swallows a coincident edge
   always_comb begin
      q_d = q_q;
      if (!d_use[IdxClrN]) begin
         q_d = 4'b0000;
      end else if (pin_edge) begin
         unique case ({d_use[IdxS1], d_use[IdxS0]})
            2'b00:   q_d = q_q;
            2'b01:   q_d = {d_use[IdxSr], q_q[3:1]};
            2'b10:   q_d = {q_q[2:0], d_use[IdxSl]};
            default: q_d = {d_use[IdxA], d_use[IdxB], d_use[IdxC], d_use[IdxD]};
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_q <= 4'b0000;
      end else begin
         q_q <= q_d;
      end
   end

   assign port15 = q_q[3];
   assign port14 = q_q[2];
   assign port13 = q_q[1];
   assign port12 = q_q[0];

endmodule

// File: tb/tb_ic74x194.sv
// Self-checking bench for ic74x194: directed datasheet scenarios plus randomized pins,
// checked every cycle against a sample-history model of the chip.
module tb_ic74x194;

`ifdef IC74X194_GLITCH_FILTER_EN
   localparam int Lat = 4;
`else
   localparam int Lat = 3;
`endif

   logic clk, rst;
   logic port1, port2, port3, port4, port5, port6, port7, port8;
   logic port9, port10, port11, port16;
   logic port12, port13, port14, port15;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic clk, clr_n, sr, a, b, c, d, sl, s1, s0;
   } pins_t;

   // hist[k] = pins as seen at the system-clock edge k+1 edges ago
   pins_t      hist [4];
   logic [3:0] mq;

   ic74x194 dut (
      .clk(clk), .rst(rst),
      .port1(port1), .port2(port2), .port3(port3), .port4(port4),
      .port5(port5), .port6(port6), .port7(port7), .port8(port8),
      .port9(port9), .port10(port10), .port11(port11),
      .port12(port12), .port13(port13), .port14(port14), .port15(port15),
      .port16(port16)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic pins_t cur_pins();
      pins_t p;
      p = {port11, port1, port2, port3, port4, port5, port6, port7, port10, port9};
      return p;
   endfunction

   function automatic pins_t reset_pins();
      pins_t p;
      p = '0;
      p.clk = 1'b1;
      return p;
   endfunction

   // Chip behaviour: act on the pins seen Lat-1 edges ago if that sample is a CLK rise
   function automatic logic [3:0] model_next();
      pins_t      p;
      logic       rise;
      logic [3:0] r;
`ifdef IC74X194_GLITCH_FILTER_EN
      p    = hist[2];
      rise = hist[2].clk && hist[1].clk && !hist[3].clk;
`else
      p    = hist[1];
      rise = hist[1].clk && !hist[2].clk;
`endif
      r = mq;
      if (!p.clr_n) r = 4'd0;
      else if (rise) begin
         case ({p.s1, p.s0})
            2'b01:   r = (mq >> 1) | (p.sr ? 4'd8 : 4'd0);
            2'b10:   r = (mq << 1) | (p.sl ? 4'd1 : 4'd0);
            2'b11:   r = {p.a, p.b, p.c, p.d};
            default: r = mq;
         endcase
      end
      return r;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mq <= 4'd0;
         for (int i = 0; i < 4; i++) hist[i] <= reset_pins();
      end else begin
         mq      <= model_next();
         hist[0] <= cur_pins();
         for (int i = 1; i < 4; i++) hist[i] <= hist[i-1];
      end
   end

   always @(posedge clk) begin
      #2;
      checks++;
      if ({port15, port14, port13, port12} !== mq) begin
         errors++;
         $display("FAIL model_cmp t=%0t: got QA..QD=%b want %b", $time,
                  {port15, port14, port13, port12}, mq);
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check4(input string name, input logic [3:0] want);
      checks++;
      if ({port15, port14, port13, port12} !== want) begin
         errors++;
         $display("FAIL %s: got QA..QD=%b want %b", name, {port15, port14, port13, port12}, want);
      end
   endtask

   task automatic set_mode(input logic [1:0] s, input logic [3:0] abcd);
      {port10, port9}              = s;
      {port3, port4, port5, port6} = abcd;
   endtask

   task automatic pin_rise();
      port11 = 1'b0;
      cyc(2);
      port11 = 1'b1;
      cyc(Lat + 2);
   endtask

   logic [3:0] sr_bits;
   logic [3:0] sr_want [4];

   initial begin
      rst = 1'b1;
      {port1, port2, port3, port4, port5, port6, port7, port8} = 8'b1000_0000;
      {port9, port10, port16} = 3'b001;
      port11 = 1'b1;
      cyc(3);
      check4("reset_q", 4'b0000);
      rst = 1'b0;
      cyc(6);
      check4("clk_high_across_release", 4'b0000);

      // Parallel load with latency pinned on both sides of the update edge
      set_mode(2'b11, 4'b1011);
      port11 = 1'b0;
      cyc(2);
      port11 = 1'b1;
      cyc(Lat - 1);
      check4("load_before_latency", 4'b0000);
      cyc(1);
      check4("load_at_latency", 4'b1011);
      cyc(2);

      sr_bits = 4'b0110;
      sr_want[0] = 4'b0101; sr_want[1] = 4'b1010; sr_want[2] = 4'b1101; sr_want[3] = 4'b0110;
      set_mode(2'b01, 4'b0000);
      for (int i = 0; i < 4; i++) begin
         port2 = sr_bits[3-i];
         pin_rise();
         check4($sformatf("shift_right_%0d", i), sr_want[i]);
      end

      set_mode(2'b11, 4'b0001);
      pin_rise();
      check4("load_0001", 4'b0001);
      set_mode(2'b10, 4'b0000);
      port7 = 1'b1;
      pin_rise();
      check4("shift_left_0", 4'b0011);
      pin_rise();
      check4("shift_left_1", 4'b0111);

      // Clear coincident with a load edge
      set_mode(2'b11, 4'b1111);
      pin_rise();
      check4("load_1111", 4'b1111);
      port11 = 1'b0;
      cyc(2);
      set_mode(2'b11, 4'b1010);
      port1  = 1'b0;
      port11 = 1'b1;
      cyc(Lat + 2);
      check4("clear_priority", 4'b0000);
      port1 = 1'b1;
      pin_rise();
      check4("load_after_clear", 4'b1010);

      set_mode(2'b00, 4'b0101);
      for (int i = 0; i < 5; i++) pin_rise();
      check4("hold_mode", 4'b1010);
      set_mode(2'b11, 4'b0101);
      port11 = 1'b0;
      cyc(Lat + 3);
      check4("falling_edge_ignored", 4'b1010);

      // One-cycle glitch, then a two-cycle pulse
      set_mode(2'b11, 4'b0110);
      port11 = 1'b1;
      cyc(1);
      port11 = 1'b0;
      cyc(Lat + 3);
`ifdef IC74X194_GLITCH_FILTER_EN
      check4("short_pulse", 4'b1010);
`else
      check4("short_pulse", 4'b0110);
`endif
      set_mode(2'b11, 4'b0011);
      port11 = 1'b1;
      cyc(2);
      port11 = 1'b0;
      cyc(Lat + 3);
      check4("two_cycle_pulse", 4'b0011);

      // Random pins, occasional clear and asynchronous reset
      for (int i = 0; i < 600; i++) begin
         {port2, port3, port4, port5, port6, port7, port9, port10} = 8'($urandom_range(0, 255));
         port11 = 1'($urandom_range(0, 1));
         port1  = ($urandom_range(0, 15) != 0);
         rst    = ($urandom_range(0, 79) == 0);
         cyc(1);
      end
      rst   = 1'b0;
      port1 = 1'b1;
      cyc(Lat + 2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ic74x194.md
# ic74x194

Cycle-based emulation of the 74LS194 4-bit bidirectional universal shift register, clocked by the single FPGA system clock. It is the operand-shift/hold stage sitting directly upstream of the ic74x86 quad XOR in the emulated ALU datapath: its QA..QD outputs drive the XOR gate inputs. Chip-level pins (CLK, CLR_n, mode, serial and parallel data) are treated as ordinary signals sampled by the system clock. The pin numbering matches the DIP-16 datasheet.

## Interface
- No parameters.
- clk  input  1  FPGA system clock; all state updates on its rising edge.
- rst  input  1  Asynchronous, active-high reset.
- port1  input  1  CLR_n, active-low clear.
- port2  input  1  SR, serial input for shift-right.
- port3, port4, port5, port6  input  1 each  Parallel data A, B, C, D.
- port7  input  1  SL, serial input for shift-left.
- port8  input  1  GND; ignored.
- port9  input  1  S0, mode select bit 0.
- port10  input  1  S1, mode select bit 1.
- port11  input  1  Chip CLK pin; its rising edge is sampled, not used as a clock.
- port12, port13, port14, port15  output  1 each  QD, QC, QB, QA.
- port16  input  1  VCC; ignored.

## Operation
- Input pipeline:
  - port11, port1, port2..7 and port9/port10 pass through an identical 2-flop synchronizer (s1, s2).
  - Data and mode are therefore aligned with the sampled CLK.
  - A history flop (h) holds the previous s2 value of CLK.
- Pin edge: asserted when s2_clk = 1 and h = 0.
- State: 4-bit register q = {QA, QB, QC, QD}, driven directly onto the outputs.
- Per system-clock cycle, in priority order:
  - If the synchronized CLR_n is 0: q <= 0000, and any pin edge in that cycle is discarded.
  - Else, on a pin edge, act on the synchronized {S1, S0}:
    - 00: hold.
    - 01: shift right. QA <= SR, QB <= QA, QC <= QB, QD <= QC.
    - 10: shift left. QD <= SL, QC <= QD, QB <= QC, QA <= QB.
    - 11: parallel load. QA <= A, QB <= B, QC <= C, QD <= D.
  - Else: q holds.
- Data, mode and serial inputs are used as sampled in the same s2 stage as the CLK edge.
- No setup/hold violation modelling is done.
- Falling edges of port11 have no effect.

## Timing
- Reset (rst = 1, asynchronous):
  - q = 0000, so port12..15 = 0 immediately.
  - All CLK synchronizer flops and h reset to 1.
  - All other synchronizer flops reset to 0.
- Reset release: a port11 held high across reset release produces no edge. A low-to-high transition after release is required.
- Latency from a port11 rise (port11 stable for at least one clk period) to the output change:
  - The output changes on the 3rd rising clk edge after port11 is first sampled high.
  - Cycle breakdown: s1 samples, then s2, then q updates.
- CLR_n assert to q = 0000: 3rd clk edge after port1 is first sampled low. Clear is level-dominant while it stays low.
- CLR_n release and a CLK rise sampled in the same cycle: the edge is honoured, because both travel through the same pipeline.
- Minimum pin pulse:
  - port11 must stay high at least 1 clk period and low at least 1 clk period for each edge to be seen.
  - Shorter pulses may be lost.
- A new pin edge is accepted every 2 clk cycles at most.
- rst asserted mid-operation: q clears at once, and any in-flight sampled edge is lost.

## Configuration
- IC74X194_GLITCH_FILTER_EN: adds a third CLK synchronizer stage (s3).
- With the macro defined:
  - A pin edge requires s3 = 1, s2 = 1 and h = 0, i.e. two consecutive high samples.
  - Single-cycle high glitches on port11 are rejected.
  - Output latency becomes the 4th clk edge after port11 is first sampled high.
  - The minimum high pulse is 2 clk periods.
  - Data, mode and CLR_n gain the matching extra stage so they stay aligned.
  - s3 resets to 1.
- Without the macro: the behaviour is exactly as described above (3-edge latency, no filtering).

## Test plan
- Reset/load:
  - Assert rst with port11 = 1, release it, and hold port11 high: outputs stay 0000 with no edge.
  - Then drive port11 low→high with S1S0 = 11 and ABCD = 1011: QA..QD = 1011 on the 3rd clk edge (4th with the filter).
- Shift right:
  - From q = 1011, apply four pin edges with S1S0 = 01 and SR = 0,1,1,0.
  - Required QA..QD after each edge: 0101, 1010, 1101, 0110.
- Shift left:
  - From q = 0001, apply two edges with S1S0 = 10 and SL = 1.
  - Required QA..QD: 0011, then 0111.
- Clear priority:
  - Hold q = 1111, drive CLR_n low in the same clk cycle as a port11 rise with S1S0 = 11, ABCD = 1010.
  - Required: q = 0000, and the load is discarded.
  - Next edge after CLR_n goes high loads 1010.
- Hold/falling edge:
  - With S1S0 = 00, toggle port11 five times: q unchanged.
  - With S1S0 = 11, a falling edge alone does not change q.
- Glitch (filter defined):
  - Apply a 1-clk-wide high pulse on port11 with S1S0 = 11: q unchanged.
  - Apply a 2-clk-wide pulse: load occurs.
  - Without the filter, the 1-clk pulse loads.
